// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
//
// Command sequencer that sits directly upstream of an SR flip-flop stage and
// generates its set/reset inputs. Commands from a valid/ready producer are
// buffered in a small FIFO and issued as single-cycle s or r pulses. Each
// issue slot is followed by a programmable idle gap. The decode makes s and r
// mutually exclusive in every cycle, and reset clears both asynchronously.
//
// Parameters
//   DEPTH        command FIFO entries (power of two, >= 2)
//   GAP          idle cycles with s=r=0 after each issue slot (0..15)
//
// Ports
//   clk_i        clock, rising-edge
//   rst_i        asynchronous active-high reset
//   cmd_valid_i  producer presents a command
//   cmd_op_i     command code: 0 set, 1 reset, 2 toggle, 3 nop
//   cmd_ready_o  FIFO can accept (registered count != DEPTH)
//   q_fb_i       flip-flop q fed back, used by toggle
//   s_o          registered set pulse
//   r_o          registered reset pulse
//   busy_o       registered: FSM not idle or FIFO not empty
//   count_o      FIFO occupancy

module sr_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  input  logic [1:0]                     cmd_op_i,
  output logic                           cmd_ready_o,
  input  logic                           q_fb_i,
  output logic                           s_o,
  output logic                           r_o,
  output logic                           busy_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Gap counter is loaded with GAP-1 and the last gap cycle is the one at 0.
  // The value is only used when GAP is non-zero.
  localparam logic [3:0] GapInit = 4'(GAP - 1);

  localparam logic [1:0] OpSet    = 2'd0;
  localparam logic [1:0] OpReset  = 2'd1;
  localparam logic [1:0] OpToggle = 2'd2;
  localparam logic [1:0] OpNop    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            busy_q, busy_d;

  logic [1:0]      mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [1:0]      head_op;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // Ready comes from the registered count, so a pop on a full FIFO only
  // re-opens the input on the following cycle.
  assign cmd_ready_o = (count_q != CntFull);
  assign fifo_empty  = (count_q == CntZero);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head_op     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_op_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      gap_cnt_q <= 4'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_q       <= s_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Every transition into StIssue pops the head; the pop decision is based on
  // the registered count, so a push in the same cycle is seen one edge later.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (GAP != 0) begin
          state_d   = StGap;
          gap_cnt_d = GapInit;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  // The op is decoded at the pop edge so the pulse is high for exactly the
  // issue cycle. Toggle drives the opposite of the current flip-flop state.
  always_comb begin
    s_d = 1'b0;
    r_d = 1'b0;
    if (pop) begin
      unique case (head_op)
        OpSet:    s_d = 1'b1;
        OpReset:  r_d = 1'b1;
        OpToggle: begin
          if (q_fb_i) begin
            r_d = 1'b1;
          end else begin
            s_d = 1'b1;
          end
        end
        OpNop:    begin
          s_d = 1'b0;
          r_d = 1'b0;
        end
        default:  begin
          s_d = 1'b0;
          r_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != StIdle) || (count_d != CntZero);
  end

  assign s_o     = s_q;
  assign r_o     = r_q;
  assign busy_o  = busy_q;
  assign count_o = count_q;

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
  sr_exclusive_a: assert property (@(posedge clk_i) !(s_q && r_q));

  count_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CntFull);

  no_pop_empty_a: assert property (@(posedge clk_i) disable iff (rst_i)
    pop |-> !fifo_empty);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer. Two instances share the clock and reset:
// u_dut_a uses GAP=2, u_dut_b uses GAP=0, both DEPTH=4. Expected pulses
// (kind and edge index) are queued as stimulus is issued; a negedge monitor
// pops and compares each pulse the DUTs produce.

`timescale 1ns/1ps

module tb_sr_cmd_sequencer;

  localparam logic [1:0] OpSet    = 2'd0;
  localparam logic [1:0] OpReset  = 2'd1;
  localparam logic [1:0] OpToggle = 2'd2;
  localparam logic [1:0] OpNop    = 2'd3;

  typedef struct {
    logic s;
    logic r;
    int   cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  int         cyc;

  logic       cmd_valid_a, cmd_valid_b;
  logic [1:0] cmd_op_a, cmd_op_b;
  logic       cmd_ready_a, cmd_ready_b;
  logic       q_fb_a, q_fb_b;
  logic       s_a, s_b, r_a, r_b;
  logic       busy_a, busy_b;
  logic [2:0] count_a, count_b;

  exp_t       qa[$];
  exp_t       qb[$];

  int         compared;
  int         mismatched;

  sr_cmd_sequencer #(
    .DEPTH(4),
    .GAP  (2)
  ) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid_a),
    .cmd_op_i   (cmd_op_a),
    .cmd_ready_o(cmd_ready_a),
    .q_fb_i     (q_fb_a),
    .s_o        (s_a),
    .r_o        (r_a),
    .busy_o     (busy_a),
    .count_o    (count_a)
  );

  sr_cmd_sequencer #(
    .DEPTH(4),
    .GAP  (0)
  ) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid_b),
    .cmd_op_i   (cmd_op_b),
    .cmd_ready_o(cmd_ready_b),
    .q_fb_i     (q_fb_b),
    .s_o        (s_b),
    .r_o        (r_b),
    .busy_o     (busy_b),
    .count_o    (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    check("sr_exclusive_a", int'(s_a & r_a), 0);
    check("sr_exclusive_b", int'(s_b & r_b), 0);
    check("count_le_depth_a", int'(count_a <= 3'd4), 1);
    check("count_le_depth_b", int'(count_b <= 3'd4), 1);
    if (s_a || r_a) begin
      if (qa.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pulse_unexpected_a: got s=%0d r=%0d at cycle %0d, required no pulse",
                 s_a, r_a, cyc);
      end else begin
        e = qa.pop_front();
        check("pulse_kind_a", int'({s_a, r_a}), int'({e.s, e.r}));
        check("pulse_cycle_a", cyc, e.cyc);
      end
    end
    if (s_b || r_b) begin
      if (qb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pulse_unexpected_b: got s=%0d r=%0d at cycle %0d, required no pulse",
                 s_b, r_b, cyc);
      end else begin
        e = qb.pop_front();
        check("pulse_kind_b", int'({s_b, r_b}), int'({e.s, e.r}));
        check("pulse_cycle_b", cyc, e.cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers. Called at posedge+1; return at posedge+1 after the accepting edge
  // with acc = index of that edge.
  // ---------------------------------------------------------------------------
  task automatic push_a(input logic [1:0] op, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    cmd_valid_a = 1'b1;
    cmd_op_a = op;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready_a) begin
        acc = cyc + 1;
        done = 1'b1;
      end
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      compared++;
      mismatched++;
      $display("FAIL push_timeout_a: got cmd_ready=0 for 40 cycles, required 1");
    end
    cmd_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [1:0] op, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    cmd_valid_b = 1'b1;
    cmd_op_b = op;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready_b) begin
        acc = cyc + 1;
        done = 1'b1;
      end
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      compared++;
      mismatched++;
      $display("FAIL push_timeout_b: got cmd_ready=0 for 40 cycles, required 1");
    end
    cmd_valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(posedge clk);
      #1;
      idle = !busy_a && !busy_b;
    end
    check("idle_reached", int'(idle), 1);
  endtask

  task automatic expect_a(input logic s, input logic r, input int c);
    exp_t e;
    e.s = s;
    e.r = r;
    e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic expect_b(input logic s, input logic r, input int c);
    exp_t e;
    e.s = s;
    e.r = r;
    e.cyc = c;
    qb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n0;
    int n;
    logic [1:0] ops[7];

    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_op_a    = OpNop;
    cmd_op_b    = OpNop;
    q_fb_a      = 1'b0;
    q_fb_b      = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_s", int'(s_a), 0);
      check("rst_r", int'(r_a), 0);
      check("rst_count", int'(count_a), 0);
      check("rst_ready", int'(cmd_ready_a), 1);
      check("rst_busy", int'(busy_a), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single set into an empty idle FIFO: pulse one edge after acceptance.
    push_a(OpSet, n);
    expect_a(1'b1, 1'b0, n + 1);
    @(negedge clk);
    check("lat_count_after_push", int'(count_a), 1);
    check("lat_busy_after_push", int'(busy_a), 1);
    @(negedge clk);
    check("lat_count_after_pop", int'(count_a), 0);
    check("lat_busy_in_issue", int'(busy_a), 1);
    wait_idle();
    check("idle_busy", int'(busy_a), 0);

    // set, nop, reset, nop, toggle(q=1) at 3-cycle spacing.
    q_fb_a = 1'b1;
    push_a(OpSet, n0);
    expect_a(1'b1, 1'b0, n0 + 1);
    expect_a(1'b0, 1'b1, n0 + 7);
    expect_a(1'b0, 1'b1, n0 + 13);
    push_a(OpNop, n);
    check("seq_accept1", n, n0 + 1);
    push_a(OpReset, n);
    check("seq_accept2", n, n0 + 2);
    push_a(OpNop, n);
    check("seq_accept3", n, n0 + 3);
    push_a(OpToggle, n);
    check("seq_accept4", n, n0 + 4);
    wait_idle();

    // Toggle with q=0 issues a set.
    q_fb_a = 1'b0;
    push_a(OpToggle, n);
    expect_a(1'b1, 1'b0, n + 1);
    wait_idle();

    // Fill to full; the 7th op waits until ready returns.
    ops = '{OpSet, OpReset, OpSet, OpReset, OpSet, OpReset, OpSet};
    push_a(ops[0], n0);
    for (int i = 0; i < 7; i++) begin
      expect_a(ops[i] == OpSet, ops[i] == OpReset, n0 + 1 + 3 * i);
    end
    for (int i = 1; i < 6; i++) begin
      push_a(ops[i], n);
      check("fill_accept", n, n0 + i);
    end
    check("full_count", int'(count_a), 4);
    check("full_ready", int'(cmd_ready_a), 0);
    push_a(ops[6], n);
    check("full_held_accept", n, n0 + 8);
    @(negedge clk);
    check("full_count_after_refill", int'(count_a), 4);
    wait_idle();

    // GAP=0: ten alternating ops, back-to-back pulses, pointers wrap twice.
    push_b(OpSet, n0);
    for (int i = 0; i < 10; i++) begin
      expect_b(i % 2 == 0, i % 2 == 1, n0 + 1 + i);
    end
    for (int i = 1; i < 10; i++) begin
      push_b((i % 2 == 0) ? OpSet : OpReset, n);
      check("wrap_accept", n, n0 + i);
    end
    wait_idle();
    check("wrap_count_end", int'(count_b), 0);

    // Simultaneous push and pop at count=2.
    q_fb_a = 1'b1;
    push_a(OpSet, n0);
    expect_a(1'b1, 1'b0, n0 + 1);
    expect_a(1'b0, 1'b1, n0 + 4);
    expect_a(1'b0, 1'b1, n0 + 7);
    expect_a(1'b1, 1'b0, n0 + 10);
    push_a(OpReset, n);
    push_a(OpToggle, n);
    check("pp_accept2", n, n0 + 2);
    @(posedge clk);
    #1;
    check("pp_count_before", int'(count_a), 2);
    push_a(OpSet, n);
    check("pp_accept3", n, n0 + 4);
    check("pp_count_after", int'(count_a), 2);
    wait_idle();

    // Reset mid-pulse with three ops queued.
    push_a(OpSet, n0);
    expect_a(1'b1, 1'b0, n0 + 1);
    push_a(OpSet, n);
    push_a(OpReset, n);
    push_a(OpSet, n);
    push_a(OpReset, n);
    check("mid_accept4", n, n0 + 4);
    check("mid_s_high", int'(s_a), 1);
    check("mid_count3", int'(count_a), 3);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_s", int'(s_a), 0);
    check("mid_rst_r", int'(r_a), 0);
    check("mid_rst_count", int'(count_a), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_count", int'(count_a), 0);
    check("post_rst_busy", int'(busy_a), 0);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_still_idle", int'(busy_a), 0);
    push_a(OpReset, n);
    expect_a(1'b0, 1'b1, n + 1);
    wait_idle();

    repeat (3) @(posedge clk);
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
